// File: rtl/data_mem_stage_pkg.sv
// Shared definitions for the data memory stage.
//   DATA_W           : datapath width of the RAM and load/store buses
//   SZ_*             : req_size encodings (3 is treated as word)
//   state_t          : load/store FSM states
//   is_misaligned()  : alignment check for a size / low address pair
package data_mem_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  // Halfwords need an even address; words (size 2 or 3) need word alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic r_mis;
    r_mis = 1'b0;
    if (size == SZ_HALF) r_mis = lo[0];
    else if (size[1])    r_mis = (lo != 2'b00);
    return r_mis;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Dual-port synchronous data RAM, 2^ADDR_W words of DATA_W bits.
//   clk, rst      : clock; rst clears only the read-data registers
//   i_a_en        : port A enable (read, and write when i_a_we)
//   i_a_we        : port A write strobe
//   i_a_be        : port A byte-lane write enables, lane 0 = bits 7:0
//   i_a_addr      : port A word address
//   i_a_wdata     : port A write data
//   o_a_rdata     : port A registered read data (read-first)
//   i_b_addr      : port B word address (read-only)
//   o_b_rdata     : port B registered read data (read-first)
module dmem_ram
  import data_mem_stage_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_a_en,
  input  logic              i_a_we,
  input  logic [3:0]        i_a_be,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [DATA_W-1:0] o_b_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_a_en && i_a_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_a_be[i]) r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
      end
    end
  end

  // Reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_a_rdata <= '0;
      o_b_rdata <= '0;
    end else begin
      if (i_a_en) o_a_rdata <= r_mem[i_a_addr];
      o_b_rdata <= r_mem[i_b_addr];
    end
  end

endmodule

// File: rtl/data_mem_stage.sv
// Load/store stage behind the ALU: byte/half/word access to an internal RAM,
// sign/zero-extended load data, and a registered debug read port.
//   clk, rst              : clock, async active-high reset
//   req_valid/req_ready   : request handshake (ready only when idle)
//   req_we, req_size      : store/load, access size
//   req_signed            : sign-extend loads
//   req_addr, req_wdata   : byte address, right-aligned store data
//   rsp_valid             : one-cycle completion pulse
//   rsp_rdata, rsp_err    : load data (0 for stores/errors), misalignment flag
//   busy                  : request in flight
//   dbg_addr, dbg_rdata   : debug word address, registered RAM word
module data_mem_stage
  import data_mem_stage_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_rdata
);

  state_t            r_state;
  logic              r_ready;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_lo;

  logic              w_accept;
  logic              w_mis;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ram_rdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_data;
  logic              w_unused_addr;

  assign req_ready = r_ready;
  assign busy      = ~r_ready;
  assign w_accept  = req_valid & r_ready;
  assign w_mis     = is_misaligned(req_size, req_addr[1:0]);

  // Addresses alias modulo the RAM size; the high bits are deliberately dropped.
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  // Store data is replicated to every lane so the byte enables alone pick the target.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_a_en    (w_accept & ~w_mis),
    .i_a_we    (req_we),
    .i_a_be    (w_be),
    .i_a_addr  (req_addr[ADDR_W+1:2]),
    .i_a_wdata (w_wdata),
    .o_a_rdata (w_ram_rdata),
    .i_b_addr  (dbg_addr),
    .o_b_rdata (dbg_rdata)
  );

  // Lane extraction uses the size/sign/offset captured at accept.
  always_comb begin
    case (r_lo)
      2'd0:    w_byte = w_ram_rdata[7:0];
      2'd1:    w_byte = w_ram_rdata[15:8];
      2'd2:    w_byte = w_ram_rdata[23:16];
      default: w_byte = w_ram_rdata[31:24];
    endcase
    w_half = r_lo[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];
    case (r_size)
      SZ_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = w_ram_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b1;
      r_size    <= SZ_BYTE;
      r_signed  <= 1'b0;
      r_lo      <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_size   <= req_size;
            r_signed <= req_signed;
            r_lo     <= req_addr[1:0];
            r_ready  <= 1'b0;
            if (w_mis || req_we) begin
              r_state   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= w_mis;
              rsp_rdata <= '0;
            end else begin
              r_state <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          r_state   <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= w_load_data;
        end
        ST_RESP: begin
          r_state   <= ST_IDLE;
          r_ready   <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_ready   <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: directed scenarios followed by
// random requests, checked against a byte-array memory model.
module tb_data_mem_stage;
  import data_mem_stage_pkg::*;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_signed = 1'b0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [31:0]       dbg_rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0] m [0:255];

  always #5 clk = ~clk;

  data_mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [7:0]  i;
    logic [7:0]  b;
    logic [15:0] h;
    i = a[7:0];
    if (sz == 2'd0) begin
      b = m[i];
      return sg ? {{24{b[7]}}, b} : {24'd0, b};
    end
    if (sz == 2'd1) begin
      h = {m[i + 8'd1], m[i]};
      return sg ? {{16{h[15]}}, h} : {16'd0, h};
    end
    return {m[i + 8'd3], m[i + 8'd2], m[i + 8'd1], m[i]};
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] i;
    i = a[7:0];
    m[i] = d[7:0];
    if (sz != 2'd0) m[i + 8'd1] = d[15:8];
    if (sz[1]) begin
      m[i + 8'd2] = d[23:16];
      m[i + 8'd3] = d[31:24];
    end
  endtask

  function automatic logic [31:0] model_word(input logic [5:0] w);
    logic [7:0] b;
    b = {w, 2'b00};
    return {m[b + 8'd3], m[b + 8'd2], m[b + 8'd1], m[b]};
  endfunction

  // Starts and ends on a falling edge; checks handshake, latency, response and
  // read-first debug behaviour of one request.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input bit cdbg);
    logic [31:0] exp_rd;
    logic [31:0] old_dbg;
    bit          exp_err;
    int          exp_lat;
    int          lat;
    exp_err = is_mis(sz, addr);
    exp_rd  = (we || exp_err) ? 32'd0 : model_load(sz, sg, addr);
    exp_lat = (we || exp_err) ? 1 : 2;
    old_dbg = model_word(dbg_addr);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    if (we && !exp_err) model_store(sz, addr, wd);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    @(negedge clk);
    chk("busy_inflight", 32'(busy), 32'd1);
    if (cdbg) chk("dbg_read_first", dbg_rdata, old_dbg);
    lat = 1;
    while (!rsp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    chk("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_dbg"}, dbg_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          seen;

    for (int i = 0; i < 256; i++) m[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Give every word a known value.
    for (int w = 0; w < 64; w++) do_req(1'b1, SZ_WORD, 1'b0, 32'(w) << 2, $urandom, 1'b0);

    dbg_addr = 6'h04;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1);

    dbg_addr = 6'h08;
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'hAAAA5580, 1'b1);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0, 1'b1);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 1'b1);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b1);

    dbg_addr = 6'h0C;
    do_req(1'b1, SZ_HALF, 1'b0, 32'h32, 32'h12348001, 1'b1);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h32, 32'h0, 1'b1);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0, 1'b1);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 1'b1);

    dbg_addr = 6'h05;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 1'b1);
    do_req(1'b1, SZ_HALF, 1'b0, 32'h15, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    chk("misaligned_untouched", dbg_rdata, model_word(6'h05));

    dbg_addr = 6'h00;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h12345678, 1'b1);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h000, 32'h0, 1'b1);
    dbg_addr = 6'h01;
    @(negedge clk);
    dbg_addr = 6'h00;
    @(negedge clk);
    chk("dbg_alias", dbg_rdata, 32'h12345678);

    // Reset during RD_WAIT: the load is dropped.
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_rdwait");
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rst_rdwait_no_rsp", 32'(seen), 32'd0);
    chk("rst_rdwait_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1);

    // Reset right after a store is accepted: the write persists.
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h44; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    model_store(SZ_WORD, 32'h44, 32'hCAFEF00D);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_store_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0, 1'b1);
    chk("rst_store_kept", model_word(6'h11), 32'hCAFEF00D);

    for (int n = 0; n < 200; n++) begin
      a  = $urandom;
      sz = 2'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz[1]) a[1:0] = 2'b00;
      end
      dbg_addr = 6'($urandom);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
